// File: rtl/sram_responder_if.sv
// rtl/sram_responder_if.sv - byte-lane SRAM bus between the CPU memory interface and sram_responder
//
// Purpose: groups the request/response signals of the byte-lane SRAM bus.
// Signals:
//   sram_addr     word address (byte address bits [XLEN-1:2])
//   sram_read     per-lane read strobes, lane i = data bits [8i+7:8i]
//   sram_write    per-lane write strobes
//   sram_wdata    lane-aligned write data
//   sram_rdata    lane-aligned read data, non-read lanes are 0
//   sram_rdata_oe per-lane output enables for the shared data bus
//   sram_ready    access complete, held until the strobes drop
//   sram_err      illegal/out-of-range request, valid with sram_ready
// Modports: master (CPU side) drives the request, slave (responder) drives the response.
interface sram_responder_if #(
  parameter int XLEN = 32
) ();
  logic [XLEN-2:0] sram_addr;
  logic [3:0]      sram_read;
  logic [3:0]      sram_write;
  logic [31:0]     sram_wdata;
  logic [31:0]     sram_rdata;
  logic [3:0]      sram_rdata_oe;
  logic            sram_ready;
  logic            sram_err;

  modport master (
    output sram_addr, sram_read, sram_write, sram_wdata,
    input  sram_rdata, sram_rdata_oe, sram_ready, sram_err
  );

  modport slave (
    input  sram_addr, sram_read, sram_write, sram_wdata,
    output sram_rdata, sram_rdata_oe, sram_ready, sram_err
  );
endinterface

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - byte-lane SRAM target with programmable wait states and ready handshake
//
// Purpose: owns a word-organised SRAM array, captures a request, waits WAIT_CYCLES,
// commits write lanes / returns read lanes, then holds sram_ready until the strobes drop.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  sram_responder_if.slave (address, strobes, wdata in; rdata, oe, ready, err out)
// Parameters: XLEN, DEPTH_LOG2 (array depth in words, log2), WAIT_CYCLES (0..15).
// Optional feature: define SRAM_RESP_RANGE_CHECK_EN to flag nonzero upper address
// bits as out of range (write suppressed, err set); otherwise the array aliases.
module sram_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  sram_responder_if.slave bus
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [XLEN-2:0] addr_q;
  logic [3:0]      rmask_q, wmask_q;
  logic [31:0]     wdata_q;
  logic [3:0]      cnt_q;
  logic [31:0]     rdata_q;
  logic [3:0]      oe_q;
  logic            ready_q, err_q;

  logic [31:0]           mem [DEPTH];
  logic                  req, illegal, out_of_range, bad, do_write;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           mem_word, rd_lanes;

  assign req      = |(bus.sram_read | bus.sram_write);
  assign idx      = addr_q[DEPTH_LOG2-1:0];
  assign mem_word = mem[idx];
  // Simultaneous read and write is illegal, but its write lanes still commit.
  assign illegal  = (|rmask_q) && (|wmask_q);

`ifdef SRAM_RESP_RANGE_CHECK_EN
  assign out_of_range = |addr_q[XLEN-2:DEPTH_LOG2];
`else
  // Upper address bits alias onto the array.
  logic unused_upper_addr;
  assign unused_upper_addr = ^addr_q[XLEN-2:DEPTH_LOG2];
  assign out_of_range      = 1'b0;
`endif

  assign bad      = illegal | out_of_range;
  assign do_write = (state_q == S_ACCESS) && !out_of_range;

  always_comb begin
    rd_lanes = 32'h0;
    for (int i = 0; i < 4; i++) begin
      rd_lanes[8*i +: 8] = rmask_q[i] ? mem_word[8*i +: 8] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req) state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt_q == 4'd0) state_d = S_ACCESS;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   if (!req) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      rmask_q <= 4'h0;
      wmask_q <= 4'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0;
      oe_q    <= 4'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req) begin
          addr_q  <= bus.sram_addr;
          rmask_q <= bus.sram_read;
          wmask_q <= bus.sram_write;
          wdata_q <= bus.sram_wdata;
          cnt_q   <= CNT_INIT;
        end
        S_WAIT: if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        S_ACCESS: begin
          ready_q <= 1'b1;
          err_q   <= bad;
          rdata_q <= bad ? 32'h0 : rd_lanes;
          oe_q    <= bad ? 4'h0 : rmask_q;
        end
        S_DONE: if (!req) begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0;
          oe_q    <= 4'h0;
        end
        default: ;
      endcase
    end
  end

  // Array is not reset; a reset coinciding with the ACCESS edge blocks the commit.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.sram_rdata    = rdata_q;
  assign bus.sram_rdata_oe = oe_q;
  assign bus.sram_ready    = ready_q;
  assign bus.sram_err      = err_q;
endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed self-checking bench for sram_responder (WAIT_CYCLES 1 and 0)
module tb_sram_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [30:0] t_addr;
  logic [3:0]  t_read, t_write;
  logic [31:0] t_wdata;
  logic        sel;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  sram_responder_if #(.XLEN(32)) bus1 ();
  sram_responder_if #(.XLEN(32)) bus0 ();

  assign bus1.sram_addr  = t_addr;
  assign bus1.sram_read  = t_read;
  assign bus1.sram_write = t_write;
  assign bus1.sram_wdata = t_wdata;
  assign bus0.sram_addr  = t_addr;
  assign bus0.sram_read  = t_read;
  assign bus0.sram_write = t_write;
  assign bus0.sram_wdata = t_wdata;

  sram_responder #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  sram_responder #(.XLEN(32), .DEPTH_LOG2(10), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  logic [31:0] o_rdata;
  logic [3:0]  o_oe;
  logic        o_ready, o_err;
  assign o_rdata = sel ? bus1.sram_rdata    : bus0.sram_rdata;
  assign o_oe    = sel ? bus1.sram_rdata_oe : bus0.sram_rdata_oe;
  assign o_ready = sel ? bus1.sram_ready    : bus0.sram_ready;
  assign o_err   = sel ? bus1.sram_err      : bus0.sram_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic [30:0] a, input logic [3:0] r,
                        input logic [3:0] w, input logic [31:0] d, input int hold,
                        output logic [31:0] rd, output logic [3:0] oe, output logic err,
                        output int lat);
    @(negedge clk);
    t_addr = a; t_read = r; t_write = w; t_wdata = d;
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (o_ready) begin
        lat = i;
        break;
      end
    end
    check_eq({tag, "_ready"}, 32'(o_ready), 32'd1);
    rd = o_rdata; oe = o_oe; err = o_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check_eq({tag, "_hold_ready"}, 32'(o_ready), 32'd1);
      check_eq({tag, "_hold_rdata"}, o_rdata, rd);
    end
    @(negedge clk);
    t_read = 4'h0; t_write = 4'h0;
    @(posedge clk); #1;
    check_eq({tag, "_release_ready"}, 32'(o_ready), 32'd0);
    check_eq({tag, "_release_oe"}, 32'(o_oe), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  task automatic wr(input string tag, input logic [30:0] a, input logic [3:0] m,
                    input logic [31:0] d, input logic exp_err);
    logic [31:0] rd; logic [3:0] oe; logic err; int lat;
    access(tag, a, 4'h0, m, d, 0, rd, oe, err, lat);
    check_eq({tag, "_lat"}, 32'(lat), sel ? 32'd2 : 32'd1);
    check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic rd_chk(input string tag, input logic [30:0] a, input logic [3:0] m,
                        input logic [31:0] exp, input int hold);
    logic [31:0] rd; logic [3:0] oe; logic err; int lat;
    access(tag, a, m, 4'h0, 32'h0, hold, rd, oe, err, lat);
    check_eq({tag, "_lat"}, 32'(lat), sel ? 32'd2 : 32'd1);
    check_eq({tag, "_rdata"}, rd, exp);
    check_eq({tag, "_oe"}, 32'(oe), 32'(m));
    check_eq({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd; logic [3:0] oe; logic err; int lat;
    rst = 1'b1; t_addr = '0; t_read = 4'h0; t_write = 4'h0; t_wdata = 32'h0; sel = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready1", 32'(bus1.sram_ready), 32'd0);
    check_eq("rst_rdata1", bus1.sram_rdata, 32'd0);
    check_eq("rst_oe1", 32'(bus1.sram_rdata_oe), 32'd0);
    check_eq("rst_err1", 32'(bus1.sram_err), 32'd0);
    check_eq("rst_ready0", 32'(bus0.sram_ready), 32'd0);
    check_eq("rst_rdata0", bus0.sram_rdata, 32'd0);
    check_eq("rst_oe0", 32'(bus0.sram_rdata_oe), 32'd0);
    check_eq("rst_err0", 32'(bus0.sram_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // full word write/read, one wait state
    wr("wr10", 31'h10, 4'hF, 32'hDEADBEEF, 1'b0);
    rd_chk("rd10", 31'h10, 4'hF, 32'hDEADBEEF, 0);

    // byte-lane merge
    wr("wr20", 31'h20, 4'hF, 32'h11223344, 1'b0);
    wr("wr20_lane1", 31'h20, 4'b0010, 32'h0000AA00, 1'b0);
    rd_chk("rd20", 31'h20, 4'hF, 32'h1122AA44, 0);
    rd_chk("rd20_lane2", 31'h20, 4'b0100, 32'h00220000, 0);

    // zero wait states, strobes held
    sel = 1'b0;
    wr("wr30_w0", 31'h30, 4'hF, 32'hCAFEF00D, 1'b0);
    rd_chk("rd30_w0_hold", 31'h30, 4'hF, 32'hCAFEF00D, 5);

    // illegal request: read and write together
    sel = 1'b1;
    wr("wr40", 31'h40, 4'hF, 32'hAABBCCDD, 1'b0);
    access("illegal", 31'h40, 4'hF, 4'h1, 32'h00000077, 0, rd, oe, err, lat);
    check_eq("illegal_err", 32'(err), 32'd1);
    check_eq("illegal_rdata", rd, 32'd0);
    check_eq("illegal_oe", 32'(oe), 32'd0);
    rd_chk("rd40", 31'h40, 4'hF, 32'hAABBCC77, 0);

    // reset during WAIT (W=1) and on the ACCESS edge (W=0): write not committed
    wr("wr50", 31'h50, 4'hF, 32'h12345678, 1'b0);
    @(negedge clk);
    t_addr = 31'h50; t_write = 4'hF; t_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_ready1", 32'(bus1.sram_ready), 32'd0);
    check_eq("midrst_ready0", 32'(bus0.sram_ready), 32'd0);
    @(negedge clk);
    t_write = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    rd_chk("rd50_w1", 31'h50, 4'hF, 32'h12345678, 0);
    sel = 1'b0;
    rd_chk("rd50_w0", 31'h50, 4'hF, 32'h12345678, 0);

    // upper address bits
    sel = 1'b1;
    wr("wr0", 31'h0, 4'hF, 32'h0BADF00D, 1'b0);
`ifdef SRAM_RESP_RANGE_CHECK_EN
    wr("wr_oor", 31'h400, 4'hF, 32'h55555555, 1'b1);
    rd_chk("rd0_after_oor", 31'h0, 4'hF, 32'h0BADF00D, 0);
`else
    wr("wr_alias", 31'h400, 4'hF, 32'h55555555, 1'b0);
    rd_chk("rd0_alias", 31'h0, 4'hF, 32'h55555555, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_responder.md
# sram_responder

Target-side model and controller for the byte-lane SRAM bus driven by the CPU memory interface. It accepts the word address, per-lane read/write strobes and write data, and inserts a programmable number of wait states. It then commits writes per byte lane or returns read data per byte lane, and completes each access with a four-phase ready handshake. It sits between the CPU memory interface and the on-chip word-organised SRAM array, which it owns.

## Interface
- `DEPTH_LOG2`, 10, log2 of array depth in 32-bit words (default 4 KiB).
- `WAIT_CYCLES`, 1, wait states inserted between request capture and access (0..15).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sram_addr` in `XLEN-1`: word address (byte address bits [XLEN-1:2]).
- `sram_read` in 4: per-byte-lane read strobes, lane i = bits [8i+7:8i].
- `sram_write` in 4: per-byte-lane write strobes.
- `sram_wdata` in 32: write data, lane-aligned.
- `sram_rdata` out 32: read data, lane-aligned; non-read lanes drive 0.
- `sram_rdata_oe` out 4: lane output enables (= captured read mask while ready); top level resolves the shared tri-state data bus.
- `sram_ready` out 1: access complete; held until strobes drop.
- `sram_err` out 1: illegal or out-of-range request flag, valid with `sram_ready`.

## Operation
- The FSM has four states: IDLE, WAIT, ACCESS, DONE.
- **IDLE:** a request is any nonzero bit in `sram_read | sram_write`. On that edge:
  - capture address, both masks and wdata;
  - go to WAIT if `WAIT_CYCLES`>0, else ACCESS;
  - load the counter with `WAIT_CYCLES`-1.
- **WAIT:** decrement the counter. Go to ACCESS on the edge where it equals 0. Strobe changes are ignored; captured values are used.
- **ACCESS:** one cycle. On the exiting edge:
  - write lanes with write-mask=1 from captured wdata;
  - register `sram_rdata` (read-mask lanes from the array word, others 0);
  - set `sram_rdata_oe` = read mask, `sram_ready`=1 and `sram_err`;
  - go to DONE.
- **DONE:** hold `sram_ready`, rdata, oe and err. On the first edge where `sram_read` and `sram_write` are both 0, clear ready/oe/err/rdata and go to IDLE.
- **Both masks nonzero:** this is an illegal request. The write lanes are committed, rdata returns 0, oe=0 and `sram_err`=1.
- **Index arithmetic:** array index = captured `sram_addr[DEPTH_LOG2-1:0]`. The upper address bits are handled per Configuration.
- **Array contents:** not reset.

## Timing
- **Reset values:** state IDLE, `sram_ready`=0, `sram_rdata`=0, `sram_rdata_oe`=0, `sram_err`=0, counter 0.
- **Latency:** request sampled at edge E. `sram_ready` rises after edge E+`WAIT_CYCLES`+1, and read data is valid in the same cycle.
- **Handshake release:** the initiator drops the strobes after seeing `sram_ready`. `sram_ready` falls one edge after the strobes are seen low.
- **Minimum request-to-request spacing:** `WAIT_CYCLES`+3 cycles.
- **Reset mid-operation:** reset has priority on every edge.
  - A write whose ACCESS edge coincides with `rst`=1 is not committed.
  - The FSM returns to IDLE and outputs go to their reset values.
- **Strobes held high after reset release:** sampled as a new request in IDLE.

## Configuration
- `SRAM_RESP_RANGE_CHECK_EN` defined:
  - any nonzero captured `sram_addr[XLEN-2:DEPTH_LOG2]` is out of range;
  - the write is suppressed, rdata=0, oe=0, `sram_err`=1, and the handshake completes normally.
- `SRAM_RESP_RANGE_CHECK_EN` undefined:
  - upper address bits are ignored, so the array aliases;
  - `sram_err` is asserted only for the both-masks-nonzero case.

## Test plan
- **Reset:** hold `rst` 3 cycles with strobes 0 → all outputs 0, no ready.
- **Full-word write then read:**
  - `WAIT_CYCLES`=1; write 0xDEADBEEF to word 0x10, mask 4'hF → ready after 2 edges;
  - drop strobes, then read 0x10 mask 4'hF → `sram_rdata`=0xDEADBEEF, oe=4'hF.
- **Byte-lane merge:**
  - over 0x11223344, write 0x0000AA00 with mask 4'b0010 → read full word returns 0x1122AA44;
  - read with mask 4'b0100 → rdata=0x00220000, oe=4'b0100.
- **Zero wait states, held strobes:**
  - `WAIT_CYCLES`=0 → ready one edge after capture;
  - holding strobes 5 cycles keeps ready high with stable data;
  - ready falls one edge after the strobes drop.
- **Illegal request:** read mask 4'hF with write mask 4'h1 simultaneously → `sram_err`=1, rdata=0, lane 0 written.
- **Reset mid-access and range check:**
  - asserting `rst` in WAIT during a write → word unchanged on a later read;
  - with `SRAM_RESP_RANGE_CHECK_EN`, writing word 1<<`DEPTH_LOG2` → err=1 and word 0 unchanged.
